// File: rtl/exc_arbiter.sv
// -----------------------------------------------------------------------------
// exc_arbiter
//   Commit-stage exception/interrupt arbiter. Picks the highest-priority
//   synchronous exception (lowest src_req index) or, when none is requested,
//   a qualified interrupt. It captures ExcCode, EPC and BD, pulses exc_valid
//   for one cycle, and holds flush until fetch acknowledges the redirect.
//
//   Optional build macro: EXC_INT_SYNC_EN
//     defined   : each int_in line passes through a two-flop synchroniser
//                 before it reaches int_pending.
//     undefined : int_pending = int_in (combinational, no added latency).
//
// Ports
//   clk            sole clock, rising edge
//   rst            asynchronous active-low reset
//   inst_valid     commit instruction valid (gates every request)
//   inst_pc        commit PC
//   in_delay_slot  commit instruction sits in a branch delay slot
//   src_req        exception requests, bit 0 = highest priority
//   src_code       ExcCode per source, slice i belongs to src_req[i]
//   int_in         interrupt lines
//   status_ie/exl/im  CP0 Status fields
//   redirect_ack   fetch accepted the exception redirect
//   exc_valid      one-cycle pulse, exception taken
//   exc_code/epc/bd  captured exception information (held until next take)
//   flush          pipeline flush, held until redirect accepted
//   busy           arbiter is not idle
//   int_pending    conditioned interrupt lines for Cause.IP
// -----------------------------------------------------------------------------
module exc_arbiter #(
    parameter int                N_SRC    = 8,
    parameter int                N_INT    = 8,
    parameter int                CODE_W   = 5,
    parameter logic [CODE_W-1:0] INT_CODE = {CODE_W{1'b0}}
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      inst_valid,
    input  logic [31:0]               inst_pc,
    input  logic                      in_delay_slot,
    input  logic [N_SRC-1:0]          src_req,
    input  logic [N_SRC*CODE_W-1:0]   src_code,
    input  logic [N_INT-1:0]          int_in,
    input  logic                      status_ie,
    input  logic                      status_exl,
    input  logic [N_INT-1:0]          status_im,
    input  logic                      redirect_ack,
    output logic                      exc_valid,
    output logic [CODE_W-1:0]         exc_code,
    output logic [31:0]               exc_epc,
    output logic                      exc_bd,
    output logic                      flush,
    output logic                      busy,
    output logic [N_INT-1:0]          int_pending
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] FLUSH    = 2'd1;
    localparam logic [1:0] WAIT_ACK = 2'd2;

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic              int_take_s;
    logic              take_s;
    logic              found_s;
    logic [CODE_W-1:0] sel_code_s;
    logic [31:0]       sel_epc_s;
    logic              exc_valid_r;
    logic              flush_r;
    logic              busy_r;
    logic [CODE_W-1:0] exc_code_r;
    logic [31:0]       exc_epc_r;
    logic              exc_bd_r;

`ifdef EXC_INT_SYNC_EN
    logic [N_INT-1:0]  sync1_r;
    logic [N_INT-1:0]  sync2_r;

    // Two-flop synchroniser per interrupt line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= {N_INT{1'b0}};
            sync2_r <= {N_INT{1'b0}};
        end else begin
            sync1_r <= int_in;
            sync2_r <= sync1_r;
        end
    end

    assign int_pending = sync2_r;
`else
    assign int_pending = int_in;
`endif

    assign int_take_s = (|(int_pending & status_im)) & status_ie & ~status_exl;
    assign take_s     = inst_valid & ((|src_req) | int_take_s);
    // EPC points at the branch when the faulting instruction is in its delay slot.
    assign sel_epc_s  = in_delay_slot ? (inst_pc - 32'd4) : inst_pc;

    // Priority select: lowest set src_req index wins, interrupt code otherwise.
    always_comb begin
        sel_code_s = INT_CODE;
        found_s    = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (src_req[i] && !found_s) begin
                sel_code_s = src_code[i*CODE_W +: CODE_W];
                found_s    = 1'b1;
            end else begin
                found_s    = found_s;
            end
        end
    end

    // Next-state logic; take is only looked at in IDLE, ack never in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (take_s) begin
                    state_nxt_s = FLUSH;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FLUSH: begin
                if (redirect_ack) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (redirect_ack) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_ACK;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State plus registered status outputs, all derived from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            exc_valid_r <= 1'b0;
            flush_r     <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            exc_valid_r <= (state_nxt_s == FLUSH);
            flush_r     <= (state_nxt_s != IDLE);
            busy_r      <= (state_nxt_s != IDLE);
        end
    end

    // Exception information is captured on take and held otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exc_code_r <= {CODE_W{1'b0}};
            exc_epc_r  <= 32'd0;
            exc_bd_r   <= 1'b0;
        end else if ((state_r == IDLE) && take_s) begin
            exc_code_r <= sel_code_s;
            exc_epc_r  <= sel_epc_s;
            exc_bd_r   <= in_delay_slot;
        end else begin
            exc_code_r <= exc_code_r;
            exc_epc_r  <= exc_epc_r;
            exc_bd_r   <= exc_bd_r;
        end
    end

    assign exc_valid = exc_valid_r;
    assign flush     = flush_r;
    assign busy      = busy_r;
    assign exc_code  = exc_code_r;
    assign exc_epc   = exc_epc_r;
    assign exc_bd    = exc_bd_r;

endmodule

// File: tb/tb_exc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_exc_arbiter
//   Self-checking bench for exc_arbiter (default parameters). Directed
//   scenarios followed by randomized transactions compared against a
//   behavioural model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_exc_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_valid = 1'b0;
    logic [31:0] inst_pc = 32'd0;
    logic        in_delay_slot = 1'b0;
    logic [7:0]  src_req = 8'd0;
    logic [39:0] src_code = 40'd0;
    logic [7:0]  int_in = 8'd0;
    logic        status_ie = 1'b0;
    logic        status_exl = 1'b0;
    logic [7:0]  status_im = 8'd0;
    logic        redirect_ack = 1'b0;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_epc;
    logic        exc_bd;
    logic        flush;
    logic        busy;
    logic [7:0]  int_pending;

    int checks = 0;
    int failures = 0;

    exc_arbiter dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_pc(inst_pc),
        .in_delay_slot(in_delay_slot), .src_req(src_req), .src_code(src_code),
        .int_in(int_in), .status_ie(status_ie), .status_exl(status_exl),
        .status_im(status_im), .redirect_ack(redirect_ack),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_epc(exc_epc),
        .exc_bd(exc_bd), .flush(flush), .busy(busy), .int_pending(int_pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_code(input int i, input logic [4:0] c);
        src_code[i*5 +: 5] = c;
    endtask

    task automatic idle_inputs();
        inst_valid = 1'b0;
        src_req    = 8'd0;
        redirect_ack = 1'b0;
    endtask

    // model state
    logic [4:0]  mdl_code [8];
    logic [4:0]  last_code;
    logic [31:0] last_epc;
    logic        last_bd;
    logic        e_int;
    logic        e_take;
    logic [4:0]  e_code;
    int          lat;
    int          n_ev;
    int          n_fl;
    int          d;
    logic [31:0] r32;

    initial begin
        // ---------------- reset state ----------------
        #2;
        chk("rst_exc_valid", 32'(exc_valid), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_code", 32'(exc_code), 32'd0);
        chk("rst_epc", exc_epc, 32'd0);
        chk("rst_bd", 32'(exc_bd), 32'd0);
        chk("rst_int_pending", 32'(int_pending), 32'd0);
        rst = 1'b1;
        tick();

        // ---------------- priority pick, no delay slot ----------------
        src_req = 8'b0010_0100;
        set_code(2, 5'h0C);
        set_code(5, 5'h0A);
        inst_pc = 32'h1000_0040;
        in_delay_slot = 1'b0;
        inst_valid = 1'b1;
        tick();
        idle_inputs();
        redirect_ack = 1'b1;
        chk("t1_exc_valid", 32'(exc_valid), 32'd1);
        chk("t1_code", 32'(exc_code), 32'h0C);
        chk("t1_epc", exc_epc, 32'h1000_0040);
        chk("t1_bd", 32'(exc_bd), 32'd0);
        chk("t1_flush", 32'(flush), 32'd1);
        tick();
        redirect_ack = 1'b0;
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_pulse_one", 32'(exc_valid), 32'd0);
        chk("t1_code_held", 32'(exc_code), 32'h0C);

        // ---------------- delay slot, EPC wrap ----------------
        src_req = 8'b0000_0001;
        set_code(0, 5'h04);
        inst_pc = 32'h8000_0000;
        in_delay_slot = 1'b1;
        inst_valid = 1'b1;
        tick();
        idle_inputs();
        in_delay_slot = 1'b0;
        redirect_ack = 1'b1;
        chk("t2_exc_valid", 32'(exc_valid), 32'd1);
        chk("t2_code", 32'(exc_code), 32'h04);
        chk("t2_epc", exc_epc, 32'h7FFF_FFFC);
        chk("t2_bd", 32'(exc_bd), 32'd1);
        tick();
        redirect_ack = 1'b0;

        // ---------------- interrupt latency ----------------
        int_in = 8'h80;
        status_im = 8'h80;
        status_ie = 1'b1;
        status_exl = 1'b0;
        inst_pc = 32'h0000_1234;
        inst_valid = 1'b1;
        lat = 11;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (exc_valid) begin
                lat = i;
                break;
            end
        end
        idle_inputs();
        redirect_ack = 1'b1;
`ifdef EXC_INT_SYNC_EN
        chk("int_latency", 32'(lat), 32'd3);
`else
        chk("int_latency", 32'(lat), 32'd1);
`endif
        chk("int_code", 32'(exc_code), 32'd0);
        chk("int_pending_7", 32'(int_pending), 32'h80);
        tick();
        redirect_ack = 1'b0;
        status_exl = 1'b1;
        inst_valid = 1'b1;
        n_ev = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_ev += int'(exc_valid);
        end
        chk("int_exl_blocked", 32'(n_ev), 32'd0);
        chk("int_exl_busy", 32'(busy), 32'd0);
        idle_inputs();
        int_in = 8'h00;
        status_im = 8'h00;
        status_exl = 1'b0;
        status_ie = 1'b0;
        repeat (3) tick();

        // ---------------- delayed ack, request ignored while busy ----------------
        src_req = 8'b0000_1000;
        set_code(3, 5'h0D);
        inst_pc = 32'h0040_0100;
        inst_valid = 1'b1;
        tick();
        idle_inputs();
        n_ev = 0;
        n_fl = 0;
        for (int c = 0; c <= 5; c++) begin
            n_ev += int'(exc_valid);
            n_fl += int'(flush);
            if (c == 2) begin
                src_req = 8'h01;
                set_code(0, 5'h1F);
                inst_valid = 1'b1;
            end else begin
                src_req = 8'h00;
                inst_valid = 1'b0;
            end
            redirect_ack = (c == 5);
            tick();
        end
        idle_inputs();
        chk("ack_flush_cycles", 32'(n_fl), 32'd6);
        chk("ack_exc_valid_cycles", 32'(n_ev), 32'd1);
        chk("ack_busy_after", 32'(busy), 32'd0);
        chk("ack_flush_after", 32'(flush), 32'd0);
        chk("ack_code_held", 32'(exc_code), 32'h0D);
        tick();
        chk("ack_no_retake", 32'(exc_valid), 32'd0);

        // ---------------- async reset mid-WAIT_ACK ----------------
        src_req = 8'b0000_0010;
        set_code(1, 5'h11);
        inst_pc = 32'h2000_0008;
        in_delay_slot = 1'b1;
        inst_valid = 1'b1;
        tick();
        idle_inputs();
        in_delay_slot = 1'b0;
        tick();
        chk("rst2_pre_busy", 32'(busy), 32'd1);
        chk("rst2_pre_flush", 32'(flush), 32'd1);
        chk("rst2_pre_epc", exc_epc, 32'h2000_0004);
        #2;
        rst = 1'b0;
        #1;
        chk("rst2_flush", 32'(flush), 32'd0);
        chk("rst2_busy", 32'(busy), 32'd0);
        chk("rst2_exc_valid", 32'(exc_valid), 32'd0);
        chk("rst2_code", 32'(exc_code), 32'd0);
        chk("rst2_epc", exc_epc, 32'd0);
        chk("rst2_bd", 32'(exc_bd), 32'd0);
        chk("rst2_int_pending", 32'(int_pending), 32'd0);
        #1;
        rst = 1'b1;
        n_ev = 0;
        n_fl = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_ev += int'(exc_valid);
            n_fl += int'(busy);
        end
        chk("rst2_no_exc_after", 32'(n_ev), 32'd0);
        chk("rst2_idle_after", 32'(n_fl), 32'd0);

        // ---------------- requests without inst_valid ----------------
        src_req = 8'hFF;
        inst_valid = 1'b0;
        n_ev = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_ev += int'(exc_valid);
        end
        chk("noval_exc", 32'(n_ev), 32'd0);
        idle_inputs();

        // ---------------- randomized against model ----------------
        last_code = 5'd0;
        last_epc  = 32'd0;
        last_bd   = 1'b0;
        for (int it = 0; it < 40; it++) begin
            r32 = $urandom;
            int_in     = r32[7:0];
            status_im  = r32[15:8];
            status_ie  = r32[16];
            status_exl = (r32[18:17] == 2'd0);
            idle_inputs();
            repeat (3) tick();
            chk("rnd_int_pending", 32'(int_pending), 32'(int_in));
            for (int i = 0; i < 8; i++) begin
                mdl_code[i] = 5'($urandom_range(0, 31));
                set_code(i, mdl_code[i]);
            end
            r32 = $urandom;
            src_req = ($urandom_range(0, 2) == 0) ? 8'h00 : r32[7:0];
            inst_valid = ($urandom_range(0, 4) != 0);
            inst_pc = $urandom;
            in_delay_slot = r32[8];
            redirect_ack = r32[9];
            // model
            e_int  = ((int_in & status_im) != 8'h00) && status_ie && !status_exl;
            e_take = inst_valid && ((src_req != 8'h00) || e_int);
            e_code = 5'd0;
            for (int i = 0; i < 8; i++) begin
                if (src_req[i]) begin
                    e_code = mdl_code[i];
                    break;
                end
            end
            if (e_take) begin
                last_code = e_code;
                last_epc  = in_delay_slot ? inst_pc - 32'd4 : inst_pc;
                last_bd   = in_delay_slot;
            end
            tick();
            idle_inputs();
            chk("rnd_exc_valid", 32'(exc_valid), 32'(e_take));
            chk("rnd_code", 32'(exc_code), 32'(last_code));
            chk("rnd_epc", exc_epc, last_epc);
            chk("rnd_bd", 32'(exc_bd), 32'(last_bd));
            if (e_take) begin
                d = $urandom_range(0, 3);
                for (int c = 0; c <= d; c++) begin
                    chk("rnd_flush", 32'(flush), 32'd1);
                    chk("rnd_pulse", 32'(exc_valid), 32'(c == 0));
                    redirect_ack = (c == d);
                    tick();
                end
                redirect_ack = 1'b0;
            end
            chk("rnd_busy_after", 32'(busy), 32'd0);
            chk("rnd_flush_after", 32'(flush), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exc_arbiter.md
EXC_ARBITER -- requirements
Module: exc_arbiter

Interface
REQ-001 SHALL have parameter N_SRC, default 8: number of synchronous exception sources; bit 0 has highest priority.
REQ-002 SHALL have parameter N_INT, default 8: number of interrupt lines, mapped to IP/IM bits.
REQ-003 SHALL have parameter CODE_W, default 5: ExcCode width.
REQ-004 SHALL have parameter INT_CODE, default 0: code reported for an interrupt.
REQ-005 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port inst_valid, input, 1: commit-stage instruction valid.
REQ-008 SHALL have port inst_pc, input, 32: commit-stage PC.
REQ-009 SHALL have port in_delay_slot, input, 1: commit instruction is in a branch delay slot.
REQ-010 SHALL have port src_req, input, N_SRC: exception requests.
REQ-011 SHALL have port src_code, input, N_SRC*CODE_W: ExcCode per source; slice i belongs to src_req[i].
REQ-012 SHALL have port int_in, input, N_INT: asynchronous interrupt lines.
REQ-013 SHALL have ports status_ie, status_exl (input, 1) and status_im (input, N_INT): CP0 Status fields.
REQ-014 SHALL have port redirect_ack, input, 1: fetch has accepted the exception redirect.
REQ-015 SHALL have port exc_valid, output, 1: one-cycle pulse, exception taken.
REQ-016 SHALL have port exc_code, output, CODE_W: registered ExcCode.
REQ-017 SHALL have ports exc_epc (output, 32) and exc_bd (output, 1): registered EPC and BD.
REQ-018 SHALL have port flush, output, 1: pipeline flush, held until redirect accepted.
REQ-019 SHALL have port busy, output, 1: state is not IDLE.
REQ-020 SHALL have port int_pending, output, N_INT: conditioned interrupt lines, for Cause.IP.

Function
REQ-021 SHALL compute int_take = |(int_pending & status_im) & status_ie & !status_exl.
REQ-022 SHALL define take = inst_valid & (|src_req | int_take); src_req and int_take are ignored when inst_valid=0.
REQ-023 SHALL select the lowest-index set src_req bit; int_take SHALL win only when src_req is all-zero, with code INT_CODE.
REQ-024 SHALL implement FSM IDLE, FLUSH, WAIT_ACK.
REQ-025 In IDLE, when take=1, SHALL capture exc_code, exc_epc = in_delay_slot ? inst_pc-4 : inst_pc (modulo 2^32) and exc_bd = in_delay_slot, then enter FLUSH.
REQ-026 In FLUSH, SHALL assert exc_valid=1 and flush=1 for exactly one cycle, then enter IDLE if redirect_ack=1, otherwise WAIT_ACK.
REQ-027 In WAIT_ACK, SHALL hold flush=1 and exc_valid=0, and SHALL enter IDLE on redirect_ack=1.
REQ-028 SHALL ignore take while busy=1; captured exc_code, exc_epc and exc_bd SHALL be held until the next take.
REQ-029 SHALL ignore redirect_ack while in IDLE.
REQ-030 SHALL have latency of exactly one cycle from take sampled to exc_valid.

Reset
REQ-031 On rst=0, SHALL immediately force state IDLE, exc_valid=0, flush=0, busy=0, exc_code=0, exc_epc=0, exc_bd=0, int_pending=0 and all synchroniser flops to 0, regardless of clock.
REQ-032 Reset asserted mid-FLUSH or mid-WAIT_ACK SHALL abandon the exception with no exc_valid after release.

Configuration
REQ-033 With EXC_INT_SYNC_EN defined, SHALL pass int_in through a two-flop synchroniser per line, so int_pending follows int_in two cycles late.
REQ-034 Without EXC_INT_SYNC_EN, SHALL drive int_pending = int_in combinationally, with zero added latency.

Verification
REQ-035 Bench SHALL check: src_req=8'b0010_0100, codes[2]=0x0C, inst_pc=0x1000_0040, bd=0, inst_valid=1 -> next cycle exc_valid=1, exc_code=0x0C, exc_epc=0x1000_0040, exc_bd=0.
REQ-036 Bench SHALL check: src_req[0]=1 (code 0x04) with inst_pc=0x8000_0000 and bd=1 -> exc_epc=0x7FFF_FFFC, exc_bd=1.
REQ-037 Bench SHALL check: int_in[7]=1, im[7]=1, ie=1, exl=0, src_req=0, inst_valid=1 -> exc_code=INT_CODE after 1+2 cycles (macro on) or 1 cycle (macro off); with exl=1, no exception ever.
REQ-038 Bench SHALL check: redirect_ack delayed 5 cycles -> flush high 6 cycles, exc_valid high 1, a src_req asserted during WAIT_ACK ignored, busy=0 after ack.
REQ-039 Bench SHALL check: rst=0 pulsed asynchronously mid-WAIT_ACK -> flush, busy and exc_valid drop before the next clock edge, and all outputs are 0.
REQ-040 Bench SHALL check: src_req=all-ones with inst_valid=0 -> no exc_valid for 10 cycles.
